// File: rtl/cache_wb_controller.sv
// N-way set-associative write-back, write-allocate data cache controller with
// true-LRU age replacement, a single-beat backing-memory port and hit/miss counters.
module cache_wb_controller #(
    parameter int CACHEENTRIES = 256,
    parameter int WAYS         = 4,
    parameter int DATALENGTH   = 32,
    parameter int TAGLENGTH    = 8,
    parameter int STATWIDTH    = 16,
    localparam int NUM_SETS    = CACHEENTRIES / WAYS,
    localparam int INDEXLENGTH = $clog2(NUM_SETS),
    localparam int AGEWIDTH    = $clog2(WAYS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             we,
    input  logic [TAGLENGTH-1:0]             tag,
    input  logic [INDEXLENGTH-1:0]           index,
    input  logic [DATALENGTH-1:0]            datain,
    output logic                             resp_valid,
    output logic                             hit,
    output logic [DATALENGTH-1:0]            dataout,
    output logic                             mem_req_valid,
    input  logic                             mem_req_ready,
    output logic                             mem_we,
    output logic [TAGLENGTH+INDEXLENGTH-1:0] mem_addr,
    output logic [DATALENGTH-1:0]            mem_wdata,
    input  logic                             mem_rvalid,
    input  logic [DATALENGTH-1:0]            mem_rdata,
    output logic [STATWIDTH-1:0]             hit_count,
    output logic [STATWIDTH-1:0]             miss_count
);

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL_REQ, FILL_WAIT} state_t;

    state_t state, state_nxt;

    logic                   req_we;
    logic [TAGLENGTH-1:0]   req_tag;
    logic [INDEXLENGTH-1:0] req_index;
    logic [DATALENGTH-1:0]  req_data;

    logic [AGEWIDTH-1:0]    vic_way;
    logic [TAGLENGTH-1:0]   vic_tag;
    logic [DATALENGTH-1:0]  vic_data;

    logic [WAYS-1:0]        valid_q [NUM_SETS];
    logic [WAYS-1:0]        dirty_q [NUM_SETS];
    logic [AGEWIDTH-1:0]    age_q   [NUM_SETS][WAYS];
    logic [TAGLENGTH-1:0]   tag_mem [NUM_SETS][WAYS];
    logic [DATALENGTH-1:0]  data_mem[NUM_SETS][WAYS];

    logic                   hit_any, free_any, vic_dirty, lru_update;
    logic [AGEWIDTH-1:0]    hit_way, free_way, old_way, victim, acc_way, acc_age;

    // Descending scan so the lowest-index matching/invalid way wins.
    always_comb begin
        hit_any  = 1'b0;
        hit_way  = '0;
        free_any = 1'b0;
        free_way = '0;
        old_way  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_index][w] && (tag_mem[req_index][w] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = AGEWIDTH'(w);
            end
            if (!valid_q[req_index][w]) begin
                free_any = 1'b1;
                free_way = AGEWIDTH'(w);
            end
            if (age_q[req_index][w] == AGEWIDTH'(WAYS - 1))
                old_way = AGEWIDTH'(w);
        end
        victim     = free_any ? free_way : old_way;
        vic_dirty  = valid_q[req_index][victim] && dirty_q[req_index][victim];
        acc_way    = (state == LOOKUP) ? hit_way : vic_way;
        acc_age    = age_q[req_index][acc_way];
        lru_update = ((state == LOOKUP) && hit_any) || ((state == FILL_WAIT) && mem_rvalid);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (req_valid) state_nxt = LOOKUP;
            LOOKUP:    state_nxt = hit_any ? IDLE : (vic_dirty ? WB : FILL_REQ);
            WB:        if (mem_req_ready) state_nxt = FILL_REQ;
            FILL_REQ:  if (mem_req_ready) state_nxt = FILL_WAIT;
            FILL_WAIT: if (mem_rvalid) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    assign req_ready     = (state == IDLE);
    assign mem_req_valid = (state == WB) || (state == FILL_REQ);
    assign mem_we        = (state == WB);
    assign mem_addr      = (state == WB)       ? {vic_tag, req_index} :
                           (state == FILL_REQ) ? {req_tag, req_index} : '0;
    assign mem_wdata     = (state == WB) ? vic_data : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            hit        <= 1'b0;
            dataout    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            req_we     <= 1'b0;
            req_tag    <= '0;
            req_index  <= '0;
            req_data   <= '0;
            vic_way    <= '0;
            vic_tag    <= '0;
            vic_data   <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGEWIDTH'(w);
            end
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    req_we    <= we;
                    req_tag   <= tag;
                    req_index <= index;
                    req_data  <= datain;
                end
                LOOKUP: if (hit_any) begin
                    resp_valid <= 1'b1;
                    hit        <= 1'b1;
                    if (hit_count != {STATWIDTH{1'b1}}) hit_count <= hit_count + 1'b1;
                    if (req_we) dirty_q[req_index][hit_way] <= 1'b1;
                    else        dataout <= data_mem[req_index][hit_way];
                end else begin
                    if (miss_count != {STATWIDTH{1'b1}}) miss_count <= miss_count + 1'b1;
                    vic_way  <= victim;
                    vic_tag  <= tag_mem[req_index][victim];
                    vic_data <= data_mem[req_index][victim];
                end
                FILL_WAIT: if (mem_rvalid) begin
                    valid_q[req_index][vic_way] <= 1'b1;
                    dirty_q[req_index][vic_way] <= req_we;
                    resp_valid <= 1'b1;
                    hit        <= 1'b0;
                    if (!req_we) dataout <= mem_rdata;
                end
                default: ;
            endcase
            if (lru_update) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AGEWIDTH'(w) == acc_way)
                        age_q[req_index][w] <= '0;
                    else if (age_q[req_index][w] < acc_age)
                        age_q[req_index][w] <= age_q[req_index][w] + 1'b1;
                end
            end
        end
    end

    // Tag and data storage carry no reset; Valid gates every use of them.
    always_ff @(posedge clk) begin
        if ((state == LOOKUP) && hit_any && req_we)
            data_mem[req_index][hit_way] <= req_data;
        if ((state == FILL_WAIT) && mem_rvalid) begin
            tag_mem[req_index][vic_way]  <= req_tag;
            data_mem[req_index][vic_way] <= req_we ? req_data : mem_rdata;
        end
    end

endmodule
